// File: rtl/rx_frame_pkg.sv
// Shared types and constants for the receive framing controller.
// States, abort codes and the default frame marker live here.
package rx_frame_pkg;

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        PAYLOAD,
        CSUM,
        HOLD
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

    // Running frame checksum is a plain modulo-256 byte sum.
    function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/rx_frame_timer.sv
// Inter-byte timeout: counts brg_en ticks while running, expire_o flags the final tick.
// Latency: expire_o is combinational on the tick that reaches TIMEOUT_TICKS; no backpressure.
module rx_frame_timer #(
    parameter int TIMEOUT_TICKS = 640,
    parameter int TMO_W         = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic brg_en_i,
    input  logic run_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam logic [TMO_W-1:0] LAST_CNT = TMO_W'(TIMEOUT_TICKS - 1);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !run_i) begin
            cnt_d = '0;
        end else if (brg_en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flag the tick that would bring the count to TIMEOUT_TICKS.
    assign expire_o = run_i && !clr_i && brg_en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/rx_frame_ctrl.sv
// Parses sync/length/payload/checksum frames from the byte receiver into a host buffer.
// Outputs are registered one cycle after the accepting edge; a completed frame is held until frame_ack.
module rx_frame_ctrl
    import rx_frame_pkg::*;
#(
    parameter int         MAX_LEN       = 64,
    parameter int         ADDR_W        = 6,
    parameter logic [7:0] SYNC_BYTE     = DEF_SYNC_BYTE,
    parameter int         TIMEOUT_TICKS = 640,
    parameter int         TMO_W         = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              brg_en,
    input  logic              rx_rda,
    input  logic [7:0]        rx_data,
    output logic              rx_clear,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic [7:0]        frame_len,
    output logic              frame_err,
    output logic [1:0]        err_code,
    input  logic              frame_ack,
    output logic              busy,
    output logic [7:0]        drop_cnt
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t            state_q;
    logic              rda_q;
    logic [7:0]        len_q;
    logic [7:0]        sum_q;
    logic [7:0]        idx_q;
    logic              rx_clear_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic              frame_done_q;
    logic [7:0]        frame_len_q;
    logic              frame_err_q;
    logic [1:0]        err_code_q;
    logic [7:0]        drop_cnt_q;

    logic       accept;
    logic       timed;
    logic       tmo_expire;
    logic [7:0] byte_sum;

    // Rising edge of the receiver's level; rda_q powers up high so a stale byte is skipped.
    assign accept   = rx_rda && !rda_q;
    assign timed    = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CSUM);
    assign byte_sum = sum8(sum_q, rx_data);

    rx_frame_timer #(
        .TIMEOUT_TICKS (TIMEOUT_TICKS),
        .TMO_W         (TMO_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .brg_en_i (brg_en),
        .run_i    (timed),
        .clr_i    (accept),
        .expire_o (tmo_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            rda_q        <= 1'b1;
            len_q        <= '0;
            sum_q        <= '0;
            idx_q        <= '0;
            rx_clear_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            frame_len_q  <= '0;
            frame_err_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
            drop_cnt_q   <= '0;
        end else begin
            rda_q        <= rx_rda;
            rx_clear_q   <= accept;
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;

            case (state_q)
                HUNT: begin
                    if (accept && rx_data == SYNC_BYTE) begin
                        state_q <= LEN;
                    end
                end
                LEN: begin
                    if (accept) begin
                        if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_LEN;
                            state_q     <= HUNT;
                        end else begin
                            len_q   <= rx_data;
                            sum_q   <= rx_data;
                            idx_q   <= '0;
                            state_q <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= idx_q[ADDR_W-1:0];
                        wr_data_q <= rx_data;
                        sum_q     <= byte_sum;
                        idx_q     <= idx_q + 8'd1;
                        if (idx_q == len_q - 8'd1) begin
                            state_q <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (accept) begin
                        if (rx_data == sum_q) begin
                            frame_done_q <= 1'b1;
                            frame_len_q  <= len_q;
                            state_q      <= HOLD;
                        end else begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_CSUM;
                            state_q     <= HUNT;
                        end
                    end
                end
                HOLD: begin
                    if (accept && drop_cnt_q != 8'hFF) begin
                        drop_cnt_q <= drop_cnt_q + 8'd1;
                    end
                    if (frame_ack) begin
                        frame_len_q <= '0;
                        state_q     <= HUNT;
                    end
                end
                default: begin
                    state_q <= HUNT;
                end
            endcase

            // An accept on the expiring tick restarts the timer instead of aborting.
            if (!accept && tmo_expire) begin
                frame_err_q <= 1'b1;
                err_code_q  <= ERR_TMO;
                state_q     <= HUNT;
            end
        end
    end

    assign rx_clear   = rx_clear_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign frame_len  = frame_len_q;
    assign frame_err  = frame_err_q;
    assign err_code   = err_code_q;
    assign busy       = (state_q != HUNT);
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl: each task drives one scenario and checks it inline.
module tb_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       brg_en;
    logic       rx_rda;
    logic [7:0] rx_data;
    logic       rx_clear;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_done;
    logic [7:0] frame_len;
    logic       frame_err;
    logic [1:0] err_code;
    logic       frame_ack;
    logic       busy;
    logic [7:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    int         wr_n = 0, clr_n = 0, done_n = 0, err_n = 0;
    logic [5:0] wa_log [256];
    logic [7:0] wd_log [256];
    logic [7:0] done_len;
    logic [1:0] err_seen;

    always #5 clk = ~clk;

    rx_frame_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .brg_en     (brg_en),
        .rx_rda     (rx_rda),
        .rx_data    (rx_data),
        .rx_clear   (rx_clear),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .frame_len  (frame_len),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .frame_ack  (frame_ack),
        .busy       (busy),
        .drop_cnt   (drop_cnt)
    );

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wa_log[wr_n[7:0]] = wr_addr;
            wd_log[wr_n[7:0]] = wr_data;
            wr_n++;
        end
        if (rx_clear === 1'b1) clr_n++;
        if (frame_done === 1'b1) begin
            done_n++;
            done_len = frame_len;
        end
        if (frame_err === 1'b1) begin
            err_n++;
            err_seen = err_code;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        rx_data = b;
        rx_rda  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rx_clear !== 1'b1 && n < 20);
        total++;
        if (rx_clear !== 1'b1) begin
            bad++;
            $display("FAIL clear_handshake byte=%h rx_clear=%b want 1", b, rx_clear);
        end
        rx_rda = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; brg_en = 1'b0; frame_ack = 1'b0;
        rx_rda = 1'b1; rx_data = 8'hA5;
        repeat (3) @(negedge clk);
        total++;
        if ({rx_clear, wr_en, frame_done, frame_err, busy} !== 5'b0 || frame_len !== 8'h00 ||
            err_code !== 2'b00 || drop_cnt !== 8'h00 || wr_addr !== 6'h00 || wr_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs clr=%b we=%b done=%b err=%b busy=%b len=%h code=%b drop=%h want all 0",
                     rx_clear, wr_en, frame_done, frame_err, busy, frame_len, err_code, drop_cnt);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (clr_n !== 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_pending_byte clears=%0d busy=%b want 0 0", clr_n, busy);
        end
        rx_rda = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_good_frame();
        logic [7:0] exp_d [3];
        int w0, c0, d0, e0;
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
        w0 = wr_n; c0 = clr_n; d0 = done_n; e0 = err_n;
        send_byte(8'hA5); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
        total++;
        if (wr_n - w0 !== 3) begin
            bad++;
            $display("FAIL good_write_count got=%0d want 3", wr_n - w0);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (wa_log[w0 + i] !== 6'(i) || wd_log[w0 + i] !== exp_d[i]) begin
                bad++;
                $display("FAIL good_write%0d got=%0d:%h want %0d:%h", i, wa_log[w0 + i], wd_log[w0 + i], i, exp_d[i]);
            end
        end
        total++;
        if (done_n - d0 !== 1 || done_len !== 8'd3 || frame_len !== 8'd3 || err_n !== e0) begin
            bad++;
            $display("FAIL good_done dones=%0d len=%0d held=%0d errs=%0d want 1 3 3 0",
                     done_n - d0, done_len, frame_len, err_n - e0);
        end
        total++;
        if (clr_n - c0 !== 6 || busy !== 1'b1) begin
            bad++;
            $display("FAIL good_clears clears=%0d busy=%b want 6 1", clr_n - c0, busy);
        end
        pulse_ack();
        total++;
        if (frame_len !== 8'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL good_ack len=%0d busy=%b want 0 0", frame_len, busy);
        end
    endtask

    task automatic test_noise_then_frame();
        int w0, d0;
        w0 = wr_n; d0 = done_n;
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        total++;
        if (wr_n !== w0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL noise_ignored writes=%0d busy=%b want 0 0", wr_n - w0, busy);
        end
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01); send_byte(8'h02); send_byte(8'h05);
        total++;
        if (wr_n - w0 !== 2 || wd_log[w0 + 1] !== 8'h02 || wa_log[w0 + 1] !== 6'd1 ||
            done_n - d0 !== 1 || frame_len !== 8'd2) begin
            bad++;
            $display("FAIL noise_frame writes=%0d last=%0d:%h dones=%0d len=%0d want 2 1:02 1 2",
                     wr_n - w0, wa_log[w0 + 1], wd_log[w0 + 1], done_n - d0, frame_len);
        end
        pulse_ack();
    endtask

    task automatic test_csum_fault();
        int w0, e0, d0;
        w0 = wr_n; e0 = err_n; d0 = done_n;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h31);
        total++;
        if (wr_n - w0 !== 2 || err_n - e0 !== 1 || err_seen !== 2'b10 || err_code !== 2'b10) begin
            bad++;
            $display("FAIL csum_err writes=%0d errs=%0d code=%b held=%b want 2 1 10 10",
                     wr_n - w0, err_n - e0, err_seen, err_code);
        end
        total++;
        if (busy !== 1'b0 || frame_len !== 8'd0 || done_n !== d0) begin
            bad++;
            $display("FAIL csum_state busy=%b len=%0d dones=%0d want 0 0 0", busy, frame_len, done_n - d0);
        end
    endtask

    task automatic test_bad_len();
        int w0, e0;
        w0 = wr_n; e0 = err_n;
        send_byte(8'hA5); send_byte(8'h00);
        total++;
        if (err_n - e0 !== 1 || err_seen !== 2'b01 || busy !== 1'b0) begin
            bad++;
            $display("FAIL len_zero errs=%0d code=%b busy=%b want 1 01 0", err_n - e0, err_seen, busy);
        end
        err_seen = 2'b00;
        send_byte(8'hA5); send_byte(8'h41);
        total++;
        if (err_n - e0 !== 2 || err_seen !== 2'b01 || wr_n !== w0) begin
            bad++;
            $display("FAIL len_over errs=%0d code=%b writes=%0d want 2 01 0", err_n - e0, err_seen, wr_n - w0);
        end
    endtask

    task automatic test_max_len();
        int w0, d0;
        w0 = wr_n; d0 = done_n;
        send_byte(8'hA5); send_byte(8'h40);
        for (int i = 0; i < 64; i++) send_byte(8'h01);
        send_byte(8'h80);
        total++;
        if (wr_n - w0 !== 64 || wa_log[w0 + 63] !== 6'd63 || done_n - d0 !== 1 || frame_len !== 8'd64) begin
            bad++;
            $display("FAIL max_len writes=%0d last_addr=%0d dones=%0d len=%0d want 64 63 1 64",
                     wr_n - w0, wa_log[w0 + 63], done_n - d0, frame_len);
        end
        pulse_ack();
    endtask

    task automatic test_timeout();
        int e0;
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'hAA);
        e0 = err_n;
        for (int t = 0; t < 639; t++) begin
            @(negedge clk); brg_en = 1'b1;
            @(negedge clk); brg_en = 1'b0;
        end
        total++;
        if (err_n !== e0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL tmo_early errs=%0d busy=%b want 0 1", err_n - e0, busy);
        end
        @(negedge clk); brg_en = 1'b1;
        @(negedge clk); brg_en = 1'b0;
        total++;
        if (frame_err !== 1'b1 || err_code !== 2'b11) begin
            bad++;
            $display("FAIL tmo_fire err=%b code=%b want 1 11", frame_err, err_code);
        end
        @(negedge clk);
        total++;
        if (err_n - e0 !== 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL tmo_state errs=%0d busy=%b want 1 0", err_n - e0, busy);
        end
    endtask

    task automatic test_hold_ack();
        int w0, d0;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        w0 = wr_n; d0 = done_n;
        send_byte(8'hA5); send_byte(8'h01);
        total++;
        if (drop_cnt !== 8'd2 || wr_n !== w0 || busy !== 1'b1 || frame_len !== 8'd1) begin
            bad++;
            $display("FAIL hold_drop drop=%0d writes=%0d busy=%b len=%0d want 2 0 1 1",
                     drop_cnt, wr_n - w0, busy, frame_len);
        end
        pulse_ack();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10); send_byte(8'h11);
        total++;
        if (done_n - d0 !== 1 || wr_n - w0 !== 1 || wd_log[w0] !== 8'h10 || drop_cnt !== 8'd2) begin
            bad++;
            $display("FAIL hold_next dones=%0d writes=%0d data=%h drop=%0d want 1 1 10 2",
                     done_n - d0, wr_n - w0, wd_log[w0], drop_cnt);
        end
        pulse_ack();
    endtask

    task automatic test_reset_mid_frame();
        int w0, d0, e0;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        w0 = wr_n; d0 = done_n; e0 = err_n;
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({wr_en, frame_done, frame_err, busy, rx_clear} !== 5'b0 || drop_cnt !== 8'd0 ||
            err_code !== 2'b00 || frame_len !== 8'd0) begin
            bad++;
            $display("FAIL midreset_outputs we=%b done=%b err=%b busy=%b drop=%0d code=%b want all 0",
                     wr_en, frame_done, frame_err, busy, drop_cnt, err_code);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send_byte(8'hA5); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
        total++;
        if (wr_n - w0 !== 3 || wa_log[w0] !== 6'd0 || wd_log[w0 + 2] !== 8'h33 ||
            done_n - d0 !== 1 || err_n !== e0 || frame_len !== 8'd3) begin
            bad++;
            $display("FAIL midreset_frame writes=%0d first_addr=%0d last=%h dones=%0d errs=%0d len=%0d want 3 0 33 1 0 3",
                     wr_n - w0, wa_log[w0], wd_log[w0 + 2], done_n - d0, err_n - e0, frame_len);
        end
        pulse_ack();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_noise_then_frame();
        test_csum_fault();
        test_bad_len();
        test_max_len();
        test_timeout();
        test_hold_ack();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog sim_time=%0t want finish before 2000000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rx_frame_ctrl.md
Name: rx_frame_ctrl

Overview:
Sequencing controller that sits downstream of the SPART byte receiver. It consumes received bytes through the receiver's rda/clear_rda handshake and parses them into framed packets: sync byte, length, payload, checksum. Each payload byte is written into a host-side buffer through a simple write port. After a frame completes, the controller holds the buffer until the host acknowledges it. An inter-byte timeout runs on the baud-generator enable.

Parameters:
MAX_LEN, 64, maximum payload length in bytes (1..255)
ADDR_W, 6, buffer address width; must satisfy 2^ADDR_W >= MAX_LEN
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_TICKS, 640, brg_en ticks allowed between bytes inside a frame (about 4 byte times)
TMO_W, 12, timeout counter width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
brg_en  in  1  1/16-baud tick from the baud generator
rx_rda  in  1  receiver data-available level
rx_data  in  8  receiver data byte
rx_clear  out  1  one-cycle pulse to the receiver's clear_rda
wr_en  out  1  buffer write strobe
wr_addr  out  ADDR_W  payload index
wr_data  out  8  payload byte
frame_done  out  1  one-cycle pulse: valid frame is in the buffer
frame_len  out  8  payload length; valid from frame_done until frame_ack
frame_err  out  1  one-cycle pulse: frame aborted
err_code  out  2  01 bad length, 10 checksum, 11 timeout; held until the next frame_err
frame_ack  in  1  host has finished with the buffer
busy  out  1  high in every state except HUNT
drop_cnt  out  8  saturating count of bytes discarded in HOLD

Behaviour:
- Reset values:
  - All outputs are 0.
  - The state is HUNT.
  - The internal rda_q register resets to 1, so a byte pending at reset release is ignored.
- Byte accept:
  - A clock edge that samples rx_rda=1 and rda_q=0 is an accept.
  - rda_q <= rx_rda every cycle.
  - rx_clear is registered and is high for exactly the cycle after each accept, in every state.
- All data outputs (wr_*, frame_done, frame_err) are registered and appear the cycle after the accept that causes them.
- States:
  - HUNT: on accept, if the byte equals SYNC_BYTE, go to LEN. Any other byte is discarded and the state stays HUNT.
  - LEN:
    - On accept, if the byte is 0 or greater than MAX_LEN: frame_err, err_code=01, go to HUNT.
    - Otherwise latch len, set sum=len and idx=0, go to PAYLOAD.
  - PAYLOAD:
    - On accept: wr_en=1, wr_addr=idx, wr_data=byte.
    - Update sum=sum+byte (mod 256) and idx=idx+1.
    - When idx reaches len-1 on this accept, go to CSUM.
  - CSUM:
    - On accept, if the byte equals sum: frame_done, set frame_len=len, go to HOLD.
    - Otherwise: frame_err, err_code=10, go to HUNT.
  - HOLD:
    - Accepted bytes are cleared and discarded; drop_cnt increments, saturating at 255.
    - On frame_ack, frame_len returns to 0 and the state goes to HUNT.
    - frame_ack in any other state is ignored.
- Timeout:
  - The counter clears on every accept and on entry to LEN.
  - In LEN, PAYLOAD and CSUM it increments on each brg_en.
  - When it reaches TIMEOUT_TICKS: frame_err, err_code=11, go to HUNT.
  - If a timeout and an accept occur in the same cycle, the accept wins.
- Writes are never issued for SYNC_BYTE, length or checksum bytes.
- Reset mid-frame: the state returns to HUNT, no further writes occur, and no frame_done or frame_err is emitted.
- drop_cnt clears only on rst.

Decomposition:
- Package rx_frame_pkg:
  - state enum (HUNT, LEN, PAYLOAD, CSUM, HOLD)
  - err_code constants (ERR_LEN=2'b01, ERR_CSUM=2'b10, ERR_TMO=2'b11)
  - default SYNC_BYTE
- One sub-module, rx_frame_timer: brg_en-driven counter with clear input and expire output, parameterised by TIMEOUT_TICKS and TMO_W.

Test Plan:
- Good frame: bytes A5 03 11 22 33 69 -> three writes (0:11, 1:22, 2:33); frame_done with frame_len=3; no frame_err; exactly six rx_clear pulses.
- Noise then frame: bytes 00 FF 5A, then a good frame -> first three bytes produce no writes; the frame completes normally.
- Checksum fault: A5 02 10 20 31 -> two writes; frame_err with err_code=10; state HUNT; frame_len stays 0.
- Bad length: A5 00, then A5 41 with MAX_LEN=64 -> two frame_err pulses with err_code=01; no writes.
- Timeout: A5 04 AA, then a line idle for 640 brg_en ticks -> frame_err with err_code=11 on tick 640; busy drops to 0.
- HOLD and ack, plus reset:
  - Good frame, then 2 bytes before frame_ack -> drop_cnt=2, no writes.
  - After frame_ack, a new frame is accepted.
  - rst asserted mid-PAYLOAD -> all outputs return to 0 and the next good frame parses correctly.
